// File: rtl/imm_extend_pipe.sv
// rtl/imm_extend_pipe.sv - two-stage valid/ready immediate extender (sext/zext/upper/sext-shl)
module imm_extend_pipe #(
    parameter int DATA_W = 24,
    parameter int IN_W   = 18,
    parameter int SHIFT  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   in_imm,
    input  logic [1:0]        in_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_ovf
);

    // SHIFT+1 low ones: the sign-bit window that must be uniform for a lossless shift.
    localparam logic [DATA_W-1:0] OVF_MASK =
        ({{(DATA_W-1){1'b0}}, 1'b1} << (SHIFT + 1)) - {{(DATA_W-1){1'b0}}, 1'b1};

    logic              r_s1_valid;
    logic [IN_W-1:0]   r_imm;
    logic [1:0]        r_mode;
    logic              r_s2_valid;
    logic [DATA_W-1:0] r_data;
    logic              r_ovf;

    logic              w_adv1;
    logic              w_adv2;
    logic [DATA_W-1:0] w_sext;
    logic [DATA_W-1:0] w_zext;
    logic [DATA_W-1:0] w_upper;
    logic [DATA_W-1:0] w_win;
    logic [DATA_W-1:0] w_data;
    logic              w_ovf;

    assign w_adv2    = !r_s2_valid || out_ready;
    assign w_adv1    = !r_s1_valid || w_adv2;
    assign in_ready  = w_adv1;
    assign out_valid = r_s2_valid;
    assign out_data  = r_data;
    assign out_ovf   = r_ovf;

    always_comb begin
        w_sext                    = {DATA_W{r_imm[IN_W-1]}};
        w_sext[IN_W-1:0]          = r_imm;
        w_zext                    = '0;
        w_zext[IN_W-1:0]          = r_imm;
        w_upper                   = '0;
        w_upper[DATA_W-1 -: IN_W] = r_imm;
        w_win                     = (w_sext >> (DATA_W - 1 - SHIFT)) & OVF_MASK;
        w_data                    = w_sext;
        w_ovf                     = 1'b0;
        case (r_mode)
            2'd0: w_data = w_sext;
            2'd1: w_data = w_zext;
            2'd2: w_data = w_upper;
            default: begin
                w_data = w_sext << SHIFT;
                w_ovf  = (w_win != '0) && (w_win != OVF_MASK);
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_imm      <= '0;
            r_mode     <= '0;
            r_data     <= '0;
            r_ovf      <= 1'b0;
        end else if (flush) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
        end else begin
            if (w_adv2) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_data <= w_data;
                    r_ovf  <= w_ovf;
                end
            end
            if (w_adv1) begin
                r_s1_valid <= in_valid;
                if (in_valid) begin
                    r_imm  <= in_imm;
                    r_mode <= in_mode;
                end
            end
        end
    end

endmodule
